// File: rtl/m_unit_arbiter.sv
// Round-robin arbiter that shares one RV32M multiply/divide unit between NREQ PCPI-style requesters.
// Only M-extension ops are claimed. Operands are registered at grant, and the result is routed back to the granted port only.
module m_unit_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_instr,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_rs1,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_rs2,
  output logic [NREQ-1:0]               req_wr,
  output logic [NREQ-1:0][DATA_W-1:0]   req_rd,
  output logic [NREQ-1:0]               req_busy,
  output logic [NREQ-1:0]               req_ready,
  output logic                          m_valid,
  output logic [DATA_W-1:0]             m_instr,
  output logic [DATA_W-1:0]             m_rs1,
  output logic [DATA_W-1:0]             m_rs2,
  input  logic                          m_wr,
  input  logic [DATA_W-1:0]             m_rd,
  input  logic                          m_busy,
  input  logic                          m_ready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] G_LAST = GW'(NREQ - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last;
  logic [TW-1:0]   timer;
  logic [NREQ-1:0] busy_p0;
  logic [NREQ-1:0] elig;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;

  // Returns {found, index} for the first eligible port strictly after 'from', wrapping.
  function automatic logic [GW:0] pick_next(input logic [NREQ-1:0] el, input logic [GW-1:0] from);
    logic [GW:0] r;
    int          idx;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(from) + k) % NREQ;
      if (el[idx]) r = {1'b1, GW'(idx)};
    end
    return r;
  endfunction

  function automatic logic is_m_op(input logic [DATA_W-1:0] ins);
    return (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [GW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & is_m_op(req_instr[i]);
    end
  end

  assign {pick_found, pick_idx} = pick_next(elig, last);

  // Grant / issue / wait stage: operands are captured at grant and held until the op retires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      grant   <= '0;
      last    <= G_LAST;
      timer   <= '0;
      busy_p0 <= '0;
      m_valid <= 1'b0;
      m_instr <= '0;
      m_rs1   <= '0;
      m_rs2   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant   <= pick_idx;
            last    <= pick_idx;
            m_instr <= req_instr[pick_idx];
            m_rs1   <= req_rs1[pick_idx];
            m_rs2   <= req_rs2[pick_idx];
            m_valid <= 1'b1;
            busy_p0 <= one_hot(pick_idx);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            busy_p0 <= '0;
            state   <= S_RELEASE;
          end else if (!req_valid[grant]) begin
            m_valid <= 1'b0;
            busy_p0 <= '0;
            state   <= S_DRAIN;
          end else if (TO_EN && (timer == T_LAST)) begin
            m_valid <= 1'b0;
            busy_p0 <= '0;
            state   <= S_DRAIN;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          // An abandoned op may still complete; wait for the unit to go quiet and drop its result.
          if (!m_busy && !m_ready) state <= S_IDLE;
        end
        default: begin
          m_valid <= 1'b0;
          busy_p0 <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_busy = busy_p0;

  // Completion is forwarded combinationally so the requester sees ready in the same cycle as m_ready.
  always_comb begin
    req_ready = '0;
    req_wr    = '0;
    req_rd    = '0;
    if ((state == S_WAIT) && m_ready) begin
      req_ready[grant] = 1'b1;
      req_wr[grant]    = m_wr;
      req_rd[grant]    = m_rd;
    end
  end

endmodule
